mem_access: RTL and testbench

Memory-stage load/store unit. Sits between the EX/ME pipeline register and `ME_WB`. It takes one decoded memory operation per cycle, checks alignment, and drives a single-outstanding request/acknowledge data-memory port. It aligns and sign/zero-extends load data, and holds the pipeline with `stall_out` until the access completes.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/mem_if.sv | 31 +++
 rtl/mem_load_align.sv | 27 ++
 rtl/mem_access.sv | 133 +++++++++++++
 tb/tb_mem_access.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// funct3 codes, FSM states, legality and store-lane functions.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_t;

  function automatic logic op_legal(
    input logic [2:0] f3,
    input logic [1:0] a,
    input logic       wr
  );
    logic ok;
    unique case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !wr;
      F3_H:    ok = !a[0];
      F3_HU:   ok = !wr && !a[0];
      F3_W:    ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] lane_wdata(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] w;
    unique case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] be;
    unique case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_if.sv
// Single-outstanding request/acknowledge data-memory port.
// master = load/store unit, slave = memory.
interface mem_if;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_be_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;

  modport master (
    output mem_req_out,
    output mem_we_out,
    output mem_addr_out,
    output mem_wdata_out,
    output mem_be_out,
    input  mem_ack_in,
    input  mem_rdata_in
  );

  modport slave (
    input  mem_req_out,
    input  mem_we_out,
    input  mem_addr_out,
    input  mem_wdata_out,
    input  mem_be_out,
    output mem_ack_in,
    output mem_rdata_in
  );
endinterface

// File: rtl/mem_load_align.sv
// Load data lane select and sign/zero extension.
// Purely combinational so a cache path can share it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (1'b1)
      funct3 == F3_B:  result = {{24{b[7]}}, b};
      funct3 == F3_BU: result = {24'd0, b};
      funct3 == F3_H:  result = {{16{h[15]}}, h};
      funct3 == F3_HU: result = {16'd0, h};
      default:         result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store unit: alignment check, request FSM,
// timeout abort, store lane replication and load extension.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  mem_if.master       mem,
  output logic [31:0] load_data_out,
  output logic        stall_out,
  output logic        err_out
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] load_q, load_d;
  logic        err_q, err_d;

  logic        op;
  logic        legal;
  logic        in_idle;
  logic        in_req;
  logic        in_done;
  logic [31:0] align_data;

  mem_load_align u_align (
    .rdata   (mem.mem_rdata_in),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .result  (align_data)
  );

  assign op      = valid_in & (mem_read_in | mem_write_in);
  assign legal   = op_legal(funct3_in, addr_in[1:0], mem_write_in);
  assign in_idle = (state_q == IDLE);
  assign in_req  = (state_q == REQ);
  assign in_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    load_d  = load_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (op && legal) begin
          state_d = REQ;
          cnt_d   = '0;
          addr_d  = addr_in;
          f3_d    = funct3_in;
          we_d    = mem_write_in;
          wdata_d = lane_wdata(funct3_in, store_data_in);
          be_d    = lane_be(funct3_in, addr_in[1:0]);
          load_d  = '0;
          err_d   = 1'b0;
        end
      end
      REQ: begin
        // ack beats the timeout when both land in the same cycle
        if (mem.mem_ack_in) begin
          state_d = DONE;
          load_d  = we_q ? '0 : align_data;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          load_d  = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_req_out   = in_req;
  assign mem.mem_we_out    = in_req & we_q;
  assign mem.mem_addr_out  =
    in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem.mem_wdata_out = in_req ? wdata_q : '0;
  assign mem.mem_be_out    = in_req ? be_q : '0;

  assign load_data_out = in_done ? load_q : '0;
  assign stall_out     = (in_idle & op & legal) | in_req;
  assign err_out       =
    (in_idle & op & ~legal) | (in_done & err_q);

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a transaction-level model
// and a per-cycle compare process on the falling edge.
module tb_mem_access;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [2:0]  funct3_in = 3'd0;
  logic [31:0] addr_in = 32'd0;
  logic [31:0] store_data_in = 32'd0;
  logic [31:0] load_data_out;
  logic        stall_out;
  logic        err_out;

  mem_if bus ();

  mem_access #(.TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .funct3_in     (funct3_in),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .mem           (bus),
    .load_data_out (load_data_out),
    .stall_out     (stall_out),
    .err_out       (err_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        e_req, e_we, e_stall, e_err;
  logic [31:0] e_addr, e_wdata, e_load;
  logic [3:0]  e_be;
  logic        chk_en = 1'b0;

  int          stall_cycles, req_cycles;
  logic [31:0] done_load, last_wdata;
  logic [3:0]  last_be;
  logic        done_err, iss_err, iss_stall, last_we;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit wr,
                                 input logic [2:0] f3,
                                 input logic [31:0] a);
    int sz = m_size(f3);
    if (sz == 0) return 1'b0;
    if (wr && f3 >= 3'd4) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int sz = m_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] d);
    int sz = m_size(f3);
    if (sz == 1) return (d % 256) * 32'h01010101;
    if (sz == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (f3)
      3'd0: begin
        v = v % 256;
        if (v >= 128) v = v - 256;
      end
      3'd1: begin
        v = v % 65536;
        if (v >= 32768) v = v - 65536;
      end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic set_idle();
    e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    e_be = 0; e_stall = 0; e_err = 0; e_load = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req", 32'(bus.mem_req_out), 32'(e_req));
      chk("we", 32'(bus.mem_we_out), 32'(e_we));
      chk("addr", bus.mem_addr_out, e_addr);
      chk("wdata", bus.mem_wdata_out, e_wdata);
      chk("be", 32'(bus.mem_be_out), 32'(e_be));
      chk("stall", 32'(stall_out), 32'(e_stall));
      chk("err", 32'(err_out), 32'(e_err));
      chk("load", load_data_out, e_load);
      if (stall_out) stall_cycles++;
      if (bus.mem_req_out) begin
        req_cycles++;
        last_be = bus.mem_be_out;
        last_wdata = bus.mem_wdata_out;
        last_we = bus.mem_we_out;
      end
    end
  end

  // wait_n: REQ cycle index that carries the ack (>= TMO: never)
  // rst_at: REQ cycle index in which rst is raised (-1: never)
  task automatic run_op(input bit rd, input bit wr,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [31:0] rdata,
                        input int wait_n,
                        input int rst_at);
    bit legal;
    bit tmo;
    int nreq;
    legal = m_legal(wr, f3, a);
    tmo = (wait_n >= TMO);
    nreq = tmo ? TMO : wait_n + 1;
    @(posedge clk); #1;
    valid_in = 1; mem_read_in = rd; mem_write_in = wr;
    funct3_in = f3; addr_in = a; store_data_in = d;
    bus.mem_ack_in = 0;
    stall_cycles = 0; req_cycles = 0;
    set_idle();
    e_stall = legal; e_err = !legal;
    @(negedge clk);
    iss_err = err_out; iss_stall = stall_out;
    if (!legal) begin
      @(posedge clk); #1;
      valid_in = 0;
      set_idle();
      return;
    end
    for (int k = 0; k < nreq; k++) begin
      @(posedge clk); #1;
      e_req = 1; e_we = wr; e_addr = a & ~32'd3;
      e_be = m_be(f3, a); e_wdata = m_wdata(f3, d);
      e_stall = 1; e_err = 0; e_load = 0;
      bus.mem_ack_in = (k == wait_n);
      bus.mem_rdata_in = (k == wait_n) ? rdata : 32'h5A5A5A5A;
      if (k == rst_at) begin
        rst = 1; valid_in = 0;
        @(posedge clk); #1;
        rst = 0; bus.mem_ack_in = 0;
        set_idle();
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    bus.mem_ack_in = 0;
    set_idle();
    e_err = tmo;
    e_load = (tmo || wr) ? 32'd0 : m_load(f3, a, rdata);
    @(negedge clk);
    done_load = load_data_out; done_err = err_out;
    @(posedge clk); #1;
    valid_in = 0;
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1);
  end

  initial begin
    bus.mem_ack_in = 0;
    bus.mem_rdata_in = 0;
    set_idle();
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    run_op(1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, -1);
    chk("lw_load", done_load, 32'hDEADBEEF);
    chk("lw_stall_n", stall_cycles, 2);
    chk("lw_req_n", req_cycles, 1);
    chk("lw_be", 32'(last_be), 32'hF);

    run_op(1, 0, 3'd0, 32'h103, 0, 32'h80FF0000, 0, -1);
    chk("lb_load", done_load, 32'hFFFFFF80);
    run_op(1, 0, 3'd4, 32'h103, 0, 32'h80FF0000, 0, -1);
    chk("lbu_load", done_load, 32'h00000080);
    run_op(1, 0, 3'd5, 32'h102, 0, 32'h80FF0000, 0, -1);
    chk("lhu_load", done_load, 32'h000080FF);
    run_op(1, 0, 3'd1, 32'h102, 0, 32'h80FF0000, 1, -1);
    chk("lh_load", done_load, 32'hFFFF80FF);

    run_op(0, 1, 3'd1, 32'h206, 32'h1234ABCD, 0, 3, -1);
    chk("sh_stall_n", stall_cycles, 5);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(last_we), 1);
    chk("sh_err", 32'(done_err), 0);
    chk("sh_load", done_load, 0);

    run_op(0, 1, 3'd0, 32'h301, 32'hCAFE0077, 0, 1, -1);
    chk("sb_be", 32'(last_be), 32'h2);
    chk("sb_wdata", last_wdata, 32'h77777777);

    run_op(1, 0, 3'd2, 32'h101, 0, 0, 0, -1);
    chk("misal_err", 32'(iss_err), 1);
    chk("misal_stall", 32'(iss_stall), 0);
    chk("misal_req_n", req_cycles, 0);
    run_op(1, 0, 3'd3, 32'h100, 0, 0, 0, -1);
    chk("f3_011_err", 32'(iss_err), 1);
    chk("f3_011_req_n", req_cycles, 0);
    run_op(0, 1, 3'd4, 32'h100, 32'h55, 0, 0, -1);
    chk("sbu_err", 32'(iss_err), 1);
    run_op(0, 1, 3'd1, 32'h203, 32'h55, 0, 0, -1);
    run_op(1, 0, 3'd5, 32'h201, 0, 0, 0, -1);

    run_op(1, 0, 3'd2, 32'h40, 0, 32'h11111111, TMO, -1);
    chk("tmo_req_n", req_cycles, TMO);
    chk("tmo_err", 32'(done_err), 1);
    chk("tmo_load", done_load, 0);
    run_op(1, 0, 3'd2, 32'h44, 0, 32'h22223333, TMO - 1, -1);
    chk("edge_err", 32'(done_err), 0);
    chk("edge_load", done_load, 32'h22223333);

    run_op(1, 0, 3'd2, 32'h80, 0, 0, TMO, 1);
    chk("rst_req_n", req_cycles, 2);

    @(posedge clk); #1;
    bus.mem_ack_in = 1;
    bus.mem_rdata_in = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.mem_ack_in = 0;

    run_op(1, 0, 3'd2, 32'h84, 0, 32'h0BADF00D, 0, -1);
    chk("post_rst_load", done_load, 32'h0BADF00D);
    chk("post_rst_err", 32'(done_err), 0);

    @(posedge clk); #1;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
